// File: rtl/midori_round_ctrl.sv
// Round/stage sequencer for the masked MIDORI64 scan-flop datapath.
// Optional abort input is enabled by defining MIDORI_CTRL_ABORT_EN.
module midori_round_ctrl #(
  parameter int ROUNDS      = 16,
  parameter int SBOX_STAGES = 4,
  parameter int RND_W       = 5,
  parameter int STG_W       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef MIDORI_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             sel_load,
  output logic [RND_W-1:0] round,
  output logic [STG_W-1:0] stage,
  output logic             round_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FINAL = 2'd3
  } state_t;

  localparam logic [RND_W-1:0] ROUND_MAX = RND_W'(ROUNDS - 1);
  localparam logic [STG_W-1:0] STAGE_MAX = STG_W'(SBOX_STAGES - 1);

  state_t           state, state_next;
  logic [RND_W-1:0] round_next;
  logic [STG_W-1:0] stage_next;
  logic             sel_load_d, round_last_d, busy_d, done_d;
  logic             abort_req;

`ifdef MIDORI_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Outputs are registered from the next-state decode so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      round      <= '0;
      stage      <= '0;
      sel_load   <= 1'b0;
      round_last <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      round      <= round_next;
      stage      <= stage_next;
      sel_load   <= sel_load_d;
      round_last <= round_last_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  always_comb begin
    state_next = state;
    round_next = round;
    stage_next = stage;
    case (state)
      IDLE: begin
        round_next = '0;
        stage_next = '0;
        if (start && !abort_req) state_next = LOAD;
      end
      LOAD: begin
        round_next = '0;
        stage_next = '0;
        state_next = abort_req ? IDLE : RUN;
      end
      RUN: begin
        if (abort_req) begin
          state_next = IDLE;
          round_next = '0;
          stage_next = '0;
        end else if (stage == STAGE_MAX) begin
          // Last stage of the last round: counters hold through FINAL.
          if (round == ROUND_MAX) begin
            state_next = FINAL;
          end else begin
            stage_next = '0;
            round_next = round + 1'b1;
          end
        end else begin
          stage_next = stage + 1'b1;
        end
      end
      FINAL: begin
        state_next = IDLE;
        round_next = '0;
        stage_next = '0;
      end
      default: begin
        state_next = IDLE;
        round_next = '0;
        stage_next = '0;
      end
    endcase
  end

  always_comb begin
    sel_load_d   = (state_next == LOAD);
    busy_d       = (state_next != IDLE);
    done_d       = (state_next == FINAL);
    round_last_d = (state_next == RUN) && (round_next == ROUND_MAX);
  end

endmodule

// File: tb/tb_midori_round_ctrl.sv
// Self-checking bench for midori_round_ctrl: directed latency/boundary steps plus
// randomized start/reset traffic checked against a run-position reference model.
module tb_midori_round_ctrl;

  localparam int R     = 16;
  localparam int S     = 4;
  localparam int RW    = 5;
  localparam int SW    = 2;
  localparam int L     = R * S + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          sel_load;
  logic [RW-1:0] round;
  logic [SW-1:0] stage;
  logic          round_last;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  int pos    = -1;

  always #5 clk = ~clk;

  midori_round_ctrl #(
    .ROUNDS(R), .SBOX_STAGES(S), .RND_W(RW), .STG_W(SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef MIDORI_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .sel_load  (sel_load),
    .round     (round),
    .stage     (stage),
    .round_last(round_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_sig(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Position in a run: -1 idle, 0 load, 1..R*S run cycles, L-1 final.
  task automatic check_output(input string tag);
    logic [31:0] e_round, e_stage;
    logic        in_run;
    in_run  = (pos >= 1) && (pos <= R * S);
    e_round = 0;
    e_stage = 0;
    if (in_run) begin
      e_round = (pos - 1) / S;
      e_stage = (pos - 1) % S;
    end else if (pos == L - 1) begin
      e_round = R - 1;
      e_stage = S - 1;
    end
    check_sig({tag, "_sel_load"},   32'(sel_load),   32'(pos == 0));
    check_sig({tag, "_round"},      32'(round),      e_round);
    check_sig({tag, "_stage"},      32'(stage),      e_stage);
    check_sig({tag, "_round_last"}, 32'(round_last), 32'(in_run && (e_round == R - 1)));
    check_sig({tag, "_busy"},       32'(busy),       32'(pos >= 0));
    check_sig({tag, "_done"},       32'(done),       32'(pos == L - 1));
  endtask

  task automatic apply_stimulus(input logic s, input logic a);
    start = s;
    abort = a;
    @(posedge clk);
    if (rst_n === 1'b1) begin
      if (pos < 0) begin
        if (s && !a) pos = 0;
      end else if (a && pos <= R * S) begin
        pos = -1;
      end else begin
        pos++;
        if (pos == L) pos = -1;
      end
    end
    #1;
    check_output("step");
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1 pos = -1;
    check_output(tag);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      apply_stimulus(1'b0, 1'b0);
      n++;
    end
    check_sig(tag, 32'(busy), 0);
  endtask

  task automatic run_once(input string tag);
    int k  = 1;
    int rl = 0;
    apply_stimulus(1'b1, 1'b0);
    check_sig({tag, "_load_cycle1"}, 32'(sel_load), 1);
    while (done !== 1'b1 && k < 200) begin
      apply_stimulus(k == 10, 1'b0);
      k++;
      if (round_last === 1'b1) rl++;
    end
    check_sig({tag, "_done_cycle"}, 32'(k), 66);
    check_sig({tag, "_round_last_cycles"}, 32'(rl), 4);
    apply_stimulus(1'b1, 1'b0);
    check_sig({tag, "_idle_after_final"}, 32'(busy), 0);
    apply_stimulus(1'b0, 1'b0);
    check_sig({tag, "_no_restart"}, 32'(sel_load), 0);
  endtask

  initial begin
    int done_at[$];
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #3;
    pos = -1;
    check_output("reset_async");
    apply_stimulus(1'b1, 1'b0);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b0);

    run_once("single");

    for (int i = 1; i <= 200; i++) begin
      apply_stimulus(1'b1, 1'b0);
      if (done === 1'b1) done_at.push_back(i);
    end
    check_sig("stream_done_count", 32'(done_at.size()), 3);
    for (int j = 1; j < done_at.size(); j++)
      check_sig("stream_done_spacing", 32'(done_at[j] - done_at[j-1]), 67);
    wait_idle("stream_drain");

    apply_stimulus(1'b1, 1'b0);
    for (int i = 2; i <= 30; i++) apply_stimulus(1'b0, 1'b0);
    async_reset_pulse("reset_midrun");
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    run_once("after_reset");

`ifdef MIDORI_CTRL_ABORT_EN
    apply_stimulus(1'b1, 1'b0);
    for (int i = 2; i <= 30; i++) apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    check_sig("abort_to_idle", 32'(busy), 0);
    apply_stimulus(1'b1, 1'b1);
    check_sig("abort_priority_idle", 32'(sel_load), 0);
    apply_stimulus(1'b0, 1'b0);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic s, a;
      s = ($urandom_range(0, 9) == 0);
`ifdef MIDORI_CTRL_ABORT_EN
      a = ($urandom_range(0, 99) == 0);
`else
      a = 1'b0;
`endif
      apply_stimulus(s, a);
      if ($urandom_range(0, 499) == 0) async_reset_pulse("random_reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
